serial_tx_arbiter: RTL and testbench
====================================

Name: serial_tx_arbiter

Overview:
Shares one byte-wide serial transmitter between NUM_REQ requesters using round-robin arbitration. It latches the winning requester's byte and issues a one-cycle start pulse to the transmitter. It then tracks the transmitter's busy signal through the frame, enforces an inter-frame gap, and aborts on a watchdog timeout. It sits between client logic and the serial transmitter, mirroring the byte-oriented, LSB-first link used by the receive path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, frame payload width
GAP, 2, idle cycles enforced after each frame before the next grant (0..255)
TIMEOUT, 4095, max cycles in any wait state before abort (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; low = no new grants, an in-flight frame still completes
req  in  NUM_REQ  per-requester request, held until gnt seen
req_data  in  NUM_REQ*DATA_W  requester i's byte in bits [i*DATA_W +: DATA_W], stable while req[i] high
gnt  out  NUM_REQ  one-hot, one-cycle grant/accept pulse
tx_data  out  DATA_W  byte to transmitter, held stable from tx_start until return to IDLE
tx_start  out  1  one-cycle start pulse to transmitter
tx_busy  in  1  transmitter busy, high for the duration of a frame
owner  out  $clog2(NUM_REQ)  index of the last granted requester
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on normal frame completion
err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_n low): state=IDLE; gnt=0, tx_start=0, tx_data=0, owner=0, done=0, err=0, timer=0; last_grant=NUM_REQ-1, so requester 0 has highest priority first.
- All outputs are registered. gnt, tx_start, done and err are single-cycle pulses.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP_WAIT.
- IDLE, at an edge with en=1 and |req:
  - Select the first set req[i] searching from (last_grant+1) mod NUM_REQ upward, with wrap.
  - Register: gnt=onehot(i), tx_start=1, tx_data=req_data slice i, owner=i, last_grant=i, timer=0.
  - Go to WAIT_BUSY.
  - Latency: req sampled at edge k, so gnt and tx_start are high during cycle k+1.
- The requester must drop req[i] after seeing gnt. Req in the gnt cycle is ignored because state is no longer IDLE.
- WAIT_BUSY: timer increments each cycle.
  - tx_busy=1: go to WAIT_DONE, timer=0.
  - Else if timer==TIMEOUT-1: err pulse, go to IDLE.
- WAIT_DONE: timer increments each cycle.
  - tx_busy=0: done pulse, timer=0, go to GAP_WAIT (or IDLE if GAP==0).
  - Else if timer==TIMEOUT-1: err pulse, go to IDLE. last_grant still advances, so an aborted requester does not monopolise.
- GAP_WAIT: timer counts GAP cycles, then go to IDLE. The first new grant comes at the edge after IDLE is entered, giving a minimum of GAP+1 cycles from done to the next tx_start.
- tx_busy already high in the cycle tx_start is asserted: WAIT_BUSY exits at the next edge. This is legal.
- en deasserted mid-frame: no effect until IDLE. It then blocks grants; pending reqs are held, not dropped.
- Simultaneous requests: exactly one gnt bit is set per grant. Fairness: under constant requests from all NUM_REQ sources, each is granted once per NUM_REQ frames.
- Timer is 16 bits and never wraps. It resets on every state change.
- Reset mid-frame: everything returns to reset values immediately. No done or err pulse is generated.
- owner and tx_data hold their values in IDLE after a frame.

Test Plan:
- Single request: req=4'b0100, data 0xA5, en=1 → gnt=0100 and tx_start one cycle after; tx_data=0xA5, owner=2. Model transmitter busy for 10 cycles → done pulse, then busy=0 after GAP=2 cycles.
- All four requesting continuously with data 0x10..0x13 → grant order 0,1,2,3,0. tx_data sequence 0x10,0x11,0x12,0x13,0x10; exactly one gnt bit per grant.
- Round-robin wrap: last grant to 3, then req=4'b1001 → requester 0 granted. Next frame with req=4'b1001 → requester 3 granted.
- Timeout: tx_busy never rises, TIMEOUT=16 → err pulse 16 cycles after tx_start, state IDLE, no done pulse. Next request is granted normally.
- en low with req=4'b0001 for 20 cycles → no gnt or tx_start. Raise en → gnt one cycle later. Drop en during WAIT_DONE → frame completes with done pulse.
- Assert rst_n low during WAIT_DONE → busy=0, tx_data=0, owner=0 asynchronously. After release, req=4'b0010 is granted as first-priority search from index 0.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin arbiter sharing one serial transmitter among requesters
module serial_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST   = 16'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP_WAIT  = 2'd3
    } state_t;

    state_t             state;
    logic [15:0]        timer;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               found;

    // Round-robin search: first set request starting just after the last grant, with wrap
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign busy = (state != IDLE);

    // Grant, frame tracking, inter-frame gap and watchdog abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            gnt        <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            owner      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            gnt      <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && found) begin
                        gnt        <= NUM_REQ'(1) << pick;
                        tx_start   <= 1'b1;
                        tx_data    <= req_data[int'(pick)*DATA_W +: DATA_W];
                        owner      <= pick;
                        last_grant <= pick;
                        timer      <= '0;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        timer <= '0;
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        done  <= 1'b1;
                        timer <= '0;
                        state <= (GAP == 0) ? IDLE : GAP_WAIT;
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                GAP_WAIT: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - scoreboard bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

    localparam int K_G = 0;
    localparam int K_D = 1;
    localparam int K_E = 2;

    localparam int W_GNT  = 0;
    localparam int W_DONE = 1;
    localparam int W_ERR  = 2;
    localparam int W_IDLE = 3;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  owner;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;
    int busy_len;
    bit xmit_on;

    typedef struct {
        int         kind;
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] o;
    } ev_t;

    ev_t exp_q[$];

    serial_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_W (8),
        .GAP    (2),
        .TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .req_data(req_data),
        .gnt     (gnt),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .owner   (owner),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] g, input logic [7:0] d, input logic [1:0] o);
        ev_t e;
        e.kind = kind;
        e.g    = g;
        e.d    = d;
        e.o    = o;
        exp_q.push_back(e);
    endtask

    task automatic take(input string name, input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s actual=unexpected_event required=none", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 32'(kind), 32'(e.kind));
            ok = (e.kind == kind);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant, done or err pulse
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (gnt != 4'b0 || tx_start) begin
                take("grant", K_G, e, ok);
                if (ok) begin
                    chk("gnt", 32'(gnt), 32'(e.g));
                    chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
                    chk("tx_start", 32'(tx_start), 32'd1);
                    chk("tx_data", 32'(tx_data), 32'(e.d));
                    chk("owner", 32'(owner), 32'(e.o));
                end
            end
            if (done) take("done", K_D, e, ok);
            if (err)  take("err", K_E, e, ok);
        end
    end

    // Transmitter model: busy for busy_len cycles after each start pulse
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && xmit_on) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic wait_for(input int which, input int limit, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        for (int i = 1; i <= limit && !hit; i++) begin
            @(negedge clk);
            n = i;
            case (which)
                W_GNT:   hit = (gnt != 4'b0);
                W_DONE:  hit = done;
                W_ERR:   hit = err;
                default: hit = !busy;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL wait_%0d actual=timeout required=event_within_%0d", which, limit);
        end
    endtask

    task automatic run_frame(input logic [3:0] r, input logic [3:0] g, input logic [7:0] d, input logic [1:0] o);
        int n;
        push(K_G, g, d, o);
        push(K_D, g, d, o);
        req = r;
        wait_for(W_GNT, 100, n);
        req = 4'b0;
        wait_for(W_DONE, 100, n);
        wait_for(W_IDLE, 20, n);
    endtask

    initial begin
        #300000;
        $display("FAIL global_watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        int seen;
        total    = 0;
        bad      = 0;
        busy_len = 3;
        xmit_on  = 1'b1;
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 4'b0;
        req_data = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting continuously: order 0,1,2,3,0
        req_data = 32'h13121110;
        push(K_G, 4'b0001, 8'h10, 2'd0); push(K_D, 4'b0001, 8'h10, 2'd0);
        push(K_G, 4'b0010, 8'h11, 2'd1); push(K_D, 4'b0010, 8'h11, 2'd1);
        push(K_G, 4'b0100, 8'h12, 2'd2); push(K_D, 4'b0100, 8'h12, 2'd2);
        push(K_G, 4'b1000, 8'h13, 2'd3); push(K_D, 4'b1000, 8'h13, 2'd3);
        push(K_G, 4'b0001, 8'h10, 2'd0); push(K_D, 4'b0001, 8'h10, 2'd0);
        en  = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_for(W_GNT, 100, n);
        req = 4'b0;
        wait_for(W_DONE, 100, n);
        wait_for(W_IDLE, 20, n);

        // Single request, 10-cycle frame, gap of 2 after done
        busy_len = 10;
        req_data = 32'h00A50000;
        push(K_G, 4'b0100, 8'hA5, 2'd2);
        push(K_D, 4'b0100, 8'hA5, 2'd2);
        req = 4'b0100;
        wait_for(W_GNT, 100, n);
        req = 4'b0;
        wait_for(W_DONE, 100, n);
        wait_for(W_IDLE, 20, n);
        chk("gap_cycles", 32'(n), 32'd2);
        chk("owner_held", 32'(owner), 32'd2);
        chk("tx_data_held", 32'(tx_data), 32'hA5);

        // Round-robin wrap
        busy_len = 3;
        req_data = 32'h23000020;
        run_frame(4'b1000, 4'b1000, 8'h23, 2'd3);
        run_frame(4'b1001, 4'b0001, 8'h20, 2'd0);
        run_frame(4'b1001, 4'b1000, 8'h23, 2'd3);

        // Watchdog: transmitter never goes busy
        xmit_on  = 1'b0;
        req_data = 32'h006D5C00;
        push(K_G, 4'b0010, 8'h5C, 2'd1);
        push(K_E, 4'b0010, 8'h5C, 2'd1);
        req = 4'b0010;
        wait_for(W_GNT, 100, n);
        req = 4'b0;
        wait_for(W_ERR, 100, n);
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("idle_at_err", 32'(busy), 32'd0);
        xmit_on = 1'b1;
        run_frame(4'b0110, 4'b0100, 8'h6D, 2'd2);

        // Enable gating
        busy_len = 10;
        req_data = 32'h0000003C;
        en   = 1'b0;
        req  = 4'b0001;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt != 4'b0 || tx_start) seen++;
        end
        chk("en_low_no_grant", 32'(seen), 32'd0);
        push(K_G, 4'b0001, 8'h3C, 2'd0);
        push(K_D, 4'b0001, 8'h3C, 2'd0);
        en = 1'b1;
        wait_for(W_GNT, 10, n);
        chk("en_rise_latency", 32'(n), 32'd1);
        req = 4'b0;
        repeat (4) @(negedge clk);
        en = 1'b0;
        wait_for(W_DONE, 100, n);
        wait_for(W_IDLE, 20, n);
        en = 1'b1;

        // Reset in the middle of a frame
        req_data = 32'hD377B1A0;
        push(K_G, 4'b0100, 8'h77, 2'd2);
        req = 4'b0100;
        wait_for(W_GNT, 100, n);
        req = 4'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'h0);
        chk("midrst_owner", 32'(owner), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30 && tx_busy; i++) @(negedge clk);
        chk("tx_busy_released", 32'(tx_busy), 32'd0);
        run_frame(4'b1010, 4'b0010, 8'hB1, 2'd1);

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
